// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IC/DC main-memory arbiter: FSM state encoding and client IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RRESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    CLIENT_IC = 1'b0,
    CLIENT_DC = 1'b1
  } client_e;

  function automatic client_e other_client(input client_e c);
    client_e r;
    if (c == CLIENT_IC) begin
      r = CLIENT_DC;
    end else begin
      r = CLIENT_IC;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-client grant selection: single requester wins outright; on contention
// either round-robin against the previous grant or fixed DC priority.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic    ic_valid_i,
  input  logic    dc_valid_i,
  input  client_e last_i,
  input  logic    prio_dc_i,
  output client_e winner_o
);

  always_comb begin
    winner_o = CLIENT_IC;
    if (ic_valid_i && dc_valid_i) begin
      if (prio_dc_i) begin
        winner_o = CLIENT_DC;
      end else begin
        winner_o = other_client(last_i);
      end
    end else if (dc_valid_i) begin
      winner_o = CLIENT_DC;
    end else begin
      winner_o = CLIENT_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the instruction and data caches, one transaction at a time.
// Define MEM_ARB_DCACHE_PRIO_EN for fixed DC priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  input  logic                ic_req_rw,
  input  logic                ic_req_data_valid,
  output logic                ic_req_data_ready,
  input  logic [DATA_W-1:0]   ic_req_data_bits,
  input  logic [DATA_W/8-1:0] ic_req_data_mask,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,

  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic                dc_req_rw,
  input  logic                dc_req_data_valid,
  output logic                dc_req_data_ready,
  input  logic [DATA_W-1:0]   dc_req_data_bits,
  input  logic [DATA_W/8-1:0] dc_req_data_mask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_rw,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef MEM_ARB_DCACHE_PRIO_EN
  localparam logic PRIO_DC = 1'b1;
`else
  localparam logic PRIO_DC = 1'b0;
`endif

  arb_state_e        state_q;
  client_e           grant_q;
  client_e           last_q;
  logic [CNT_W-1:0]  cnt_q;

  client_e           winner_s;
  logic              sel_valid_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_rw_s;
  logic              sel_dvalid_s;
  logic [DATA_W-1:0] sel_dbits_s;
  logic [DATA_W/8-1:0] sel_dmask_s;
  logic              grant_dc_s;
  logic              addr_fire_s;
  logic              wdata_fire_s;

  mem_arb_rr u_rr (
    .ic_valid_i (ic_req_valid),
    .dc_valid_i (dc_req_valid),
    .last_i     (last_q),
    .prio_dc_i  (PRIO_DC),
    .winner_o   (winner_s)
  );

  assign grant_dc_s = (grant_q == CLIENT_DC);

  always_comb begin
    if (grant_dc_s) begin
      sel_valid_s  = dc_req_valid;
      sel_addr_s   = dc_req_addr;
      sel_rw_s     = dc_req_rw;
      sel_dvalid_s = dc_req_data_valid;
      sel_dbits_s  = dc_req_data_bits;
      sel_dmask_s  = dc_req_data_mask;
    end else begin
      sel_valid_s  = ic_req_valid;
      sel_addr_s   = ic_req_addr;
      sel_rw_s     = ic_req_rw;
      sel_dvalid_s = ic_req_data_valid;
      sel_dbits_s  = ic_req_data_bits;
      sel_dmask_s  = ic_req_data_mask;
    end
  end

  // Everything is idle-zero outside the phase that owns it; only the granted client sees handshakes.
  always_comb begin
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    ic_req_data_ready  = 1'b0;
    dc_req_data_ready  = 1'b0;
    ic_resp_valid      = 1'b0;
    dc_resp_valid      = 1'b0;
    case (state_q)
      ST_ADDR: begin
        mem_req_valid = sel_valid_s;
        mem_req_addr  = sel_addr_s;
        mem_req_rw    = sel_rw_s;
        ic_req_ready  = !grant_dc_s && mem_req_ready;
        dc_req_ready  = grant_dc_s && mem_req_ready;
      end
      ST_WDATA: begin
        mem_req_data_valid = sel_dvalid_s;
        mem_req_data_bits  = sel_dbits_s;
        mem_req_data_mask  = sel_dmask_s;
        ic_req_data_ready  = !grant_dc_s && mem_req_data_ready;
        dc_req_data_ready  = grant_dc_s && mem_req_data_ready;
      end
      ST_RRESP: begin
        ic_resp_valid = !grant_dc_s && mem_resp_valid;
        dc_resp_valid = grant_dc_s && mem_resp_valid;
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;

  assign addr_fire_s  = mem_req_valid && mem_req_ready;
  assign wdata_fire_s = mem_req_data_valid && mem_req_data_ready;

  // Transaction sequencer: grant is latched in IDLE, so the address phase follows one bubble later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= CLIENT_IC;
      last_q  <= CLIENT_DC;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            grant_q <= winner_s;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (addr_fire_s) begin
            last_q <= grant_q;
            cnt_q  <= '0;
            if (sel_rw_s) begin
              state_q <= ST_WDATA;
            end else begin
              state_q <= ST_RRESP;
            end
          end
        end
        ST_WDATA: begin
          if (wdata_fire_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_RRESP: begin
          if (mem_resp_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MEM_ARB_DCACHE_PRIO_EN when defined.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int MW     = DATA_W / 8;

  logic              clk;
  logic              reset;
  logic              ic_req_valid, ic_req_ready, ic_req_rw;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_data_valid, ic_req_data_ready;
  logic [DATA_W-1:0] ic_req_data_bits;
  logic [MW-1:0]     ic_req_data_mask;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_req_data_valid, dc_req_data_ready;
  logic [DATA_W-1:0] dc_req_data_bits;
  logic [MW-1:0]     dc_req_data_mask;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_data_valid, mem_req_data_ready;
  logic [DATA_W-1:0] mem_req_data_bits;
  logic [MW-1:0]     mem_req_data_mask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
    .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 1'b0; ic_req_addr = '0; ic_req_rw = 1'b0;
    ic_req_data_valid = 1'b0; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_rw = 1'b0;
    dc_req_data_valid = 1'b0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    ic_req_valid = 1'b1; mem_req_ready = 1'b1; mem_req_data_ready = 1'b1; mem_resp_valid = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready, ic_req_data_ready,
         dc_req_data_ready, ic_resp_valid, dc_resp_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_handshakes: got %b expected 00000000", {mem_req_valid, mem_req_data_valid,
               ic_req_ready, dc_req_ready, ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid});
    end
    checks++;
    if (mem_req_addr !== 28'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", mem_req_addr);
    end
    checks++;
    if ({mem_req_data_bits, mem_req_data_mask} !== 144'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0", mem_req_data_bits, mem_req_data_mask);
    end
    clear_inputs();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_ic_read();
    logic [DATA_W-1:0] exp_data;
    int beats_seen = 0;
    tick();
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000123; ic_req_rw = 1'b0; mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL ic_read_bubble: got mem_req_valid=%b expected 0", mem_req_valid);
    end
    tick();
    checks++;
    if ({mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready} !== 4'b1010 || mem_req_addr !== 28'h0000123) begin
      errors++;
      $display("FAIL ic_read_addr: got v/rw/icr/dcr=%b addr=%h expected 1010 addr=0000123",
               {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready}, mem_req_addr);
    end
    tick();
    ic_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data = 128'hA0 + 128'(i);
      mem_resp_valid = 1'b1; mem_resp_data = exp_data;
      #1;
      if (ic_resp_valid === 1'b1) beats_seen++;
      checks++;
      if ({ic_resp_valid, dc_resp_valid} !== 2'b10 || ic_resp_data !== exp_data) begin
        errors++;
        $display("FAIL ic_read_beat%0d: got ic/dc=%b data=%h expected 10 data=%h",
                 i, {ic_resp_valid, dc_resp_valid}, ic_resp_data, exp_data);
      end
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 128'hFF;
    #1;
    checks++;
    if ({ic_resp_valid, dc_resp_valid} !== 2'b00 || beats_seen !== 4) begin
      errors++;
      $display("FAIL ic_read_exact4: got ic/dc=%b beats=%0d expected 00 beats=4",
               {ic_resp_valid, dc_resp_valid}, beats_seen);
    end
    clear_inputs();
  endtask

  task automatic test_dc_write();
    logic [4:0] rdy_pat = 5'b11101;
    logic [DATA_W-1:0] exp_bits;
    int k = 0;
    tick();
    dc_req_valid = 1'b1; dc_req_addr = 28'h0ABCDEF; dc_req_rw = 1'b1;
    dc_req_data_valid = 1'b1; dc_req_data_bits = 128'h10; dc_req_data_mask = 16'hFFFF;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req_data_valid, dc_req_data_ready} !== 2'b00) begin
      errors++; $display("FAIL dc_write_idle_data: got %b expected 00", {mem_req_data_valid, dc_req_data_ready});
    end
    tick();
    checks++;
    if ({mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, mem_req_data_valid, dc_req_data_ready} !== 6'b110100
        || mem_req_addr !== 28'h0ABCDEF) begin
      errors++;
      $display("FAIL dc_write_addr: got %b addr=%h expected 110100 addr=0abcdef",
               {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, mem_req_data_valid, dc_req_data_ready},
               mem_req_addr);
    end
    tick();
    dc_req_valid = 1'b0; mem_req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      exp_bits = 128'h10 + 128'(k);
      mem_req_data_ready = rdy_pat[c]; dc_req_data_bits = exp_bits;
      #1;
      checks++;
      if (mem_req_data_valid !== 1'b1 || mem_req_data_bits !== exp_bits || mem_req_data_mask !== 16'hFFFF
          || dc_req_data_ready !== rdy_pat[c] || ic_req_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL dc_write_cycle%0d: got v=%b bits=%h mask=%h dcr=%b icr=%b expected 1 %h ffff %b 0",
                 c, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, dc_req_data_ready,
                 ic_req_data_ready, exp_bits, rdy_pat[c]);
      end
      if (rdy_pat[c]) k++;
      tick();
    end
    mem_req_data_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_data_valid, dc_req_data_ready, ic_resp_valid, dc_resp_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL dc_write_done: got %b expected 00000",
               {mem_req_valid, mem_req_data_valid, dc_req_data_ready, ic_resp_valid, dc_resp_valid});
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_g;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] exp_addr;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    exp_g = 3'b111;
`else
    exp_g = 3'b010;
`endif
    tick();
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000111;
    dc_req_valid = 1'b1; dc_req_addr = 28'h0000222;
    mem_req_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      checks++;
      if (mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL rr_bubble%0d: got mem_req_valid=%b expected 0", t, mem_req_valid);
      end
      exp_addr = exp_g[t] ? 28'h0000222 : 28'h0000111;
      tick();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr
          || {ic_req_ready, dc_req_ready} !== (exp_g[t] ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rr_grant%0d: got v=%b addr=%h ic/dc ready=%b expected 1 %h dc_wins=%b",
                 t, mem_req_valid, mem_req_addr, {ic_req_ready, dc_req_ready}, exp_addr, exp_g[t]);
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        exp_data = 128'hC0 + 128'(t * 4 + b);
        mem_resp_valid = 1'b1; mem_resp_data = exp_data;
        #1;
        checks++;
        if ({ic_resp_valid, dc_resp_valid} !== (exp_g[t] ? 2'b01 : 2'b10)
            || (exp_g[t] ? dc_resp_data : ic_resp_data) !== exp_data) begin
          errors++;
          $display("FAIL rr_resp%0d_%0d: got ic/dc=%b expected dc_wins=%b data=%h",
                   t, b, {ic_resp_valid, dc_resp_valid}, exp_g[t], exp_data);
        end
        tick();
      end
      mem_resp_valid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] exp_data;
    tick();
    ic_req_valid = 1'b1; ic_req_addr = 28'h0BEEF00; ic_req_rw = 1'b0; mem_req_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({mem_req_valid, ic_req_ready, dc_req_ready} !== 3'b100 || mem_req_addr !== 28'h0BEEF00) begin
        errors++;
        $display("FAIL bp_hold%0d: got v/icr/dcr=%b addr=%h expected 100 addr=beef00",
                 c, {mem_req_valid, ic_req_ready, dc_req_ready}, mem_req_addr);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req_valid, ic_req_ready, dc_req_ready} !== 3'b110 || mem_req_addr !== 28'h0BEEF00) begin
      errors++;
      $display("FAIL bp_fire: got v/icr/dcr=%b addr=%h expected 110 addr=beef00",
               {mem_req_valid, ic_req_ready, dc_req_ready}, mem_req_addr);
    end
    tick();
    ic_req_valid = 1'b0; mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_data = 128'hB0 + 128'(b);
      mem_resp_valid = 1'b1; mem_resp_data = exp_data;
      #1;
      checks++;
      if ({ic_resp_valid, dc_resp_valid} !== 2'b10 || ic_resp_data !== exp_data) begin
        errors++;
        $display("FAIL bp_resp%0d: got ic/dc=%b data=%h expected 10 %h",
                 b, {ic_resp_valid, dc_resp_valid}, ic_resp_data, exp_data);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_stray_resp();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 128'hDEAD;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({ic_resp_valid, dc_resp_valid, mem_req_valid} !== 3'b000) begin
        errors++;
        $display("FAIL stray_resp%0d: got ic/dc/memv=%b expected 000", c, {ic_resp_valid, dc_resp_valid, mem_req_valid});
      end
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] exp_data;
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000456; ic_req_rw = 1'b0; mem_req_ready = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_bubble: got mem_req_valid=%b expected 0", mem_req_valid);
    end
    tick();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000456) begin
      errors++; $display("FAIL mid_addr: got v=%b addr=%h expected 1 0000456", mem_req_valid, mem_req_addr);
    end
    tick();
    ic_req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 128'hD0 + 128'(b);
      tick();
    end
    mem_resp_valid = 1'b1; mem_resp_data = 128'hD2;
    #1;
    checks++;
    if (ic_resp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_third_beat: got ic_resp_valid=%b expected 1", ic_resp_valid);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_data_valid, ic_req_ready, dc_req_ready, ic_req_data_ready,
         dc_req_data_ready, ic_resp_valid, dc_resp_valid} !== 8'h00) begin
      errors++;
      $display("FAIL mid_async_reset: got %b expected 00000000", {mem_req_valid, mem_req_data_valid,
               ic_req_ready, dc_req_ready, ic_req_data_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid});
    end
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
    ic_req_valid = 1'b1; ic_req_addr = 28'h0000789; ic_req_rw = 1'b0; mem_req_ready = 1'b1;
    tick();
    checks++;
    if ({mem_req_valid, ic_req_ready} !== 2'b11 || mem_req_addr !== 28'h0000789) begin
      errors++;
      $display("FAIL post_reset_addr: got v/icr=%b addr=%h expected 11 0000789", {mem_req_valid, ic_req_ready}, mem_req_addr);
    end
    tick();
    ic_req_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_data = 128'hE0 + 128'(b);
      mem_resp_valid = 1'b1; mem_resp_data = exp_data;
      #1;
      checks++;
      if ({ic_resp_valid, dc_resp_valid} !== 2'b10 || ic_resp_data !== exp_data) begin
        errors++;
        $display("FAIL post_reset_beat%0d: got ic/dc=%b data=%h expected 10 %h",
                 b, {ic_resp_valid, dc_resp_valid}, ic_resp_data, exp_data);
      end
      tick();
    end
    #1;
    checks++;
    if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
      errors++; $display("FAIL post_reset_end: got ic/dc=%b expected 00", {ic_resp_valid, dc_resp_valid});
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_back_to_back();
    test_backpressure();
    test_stray_resp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (client IC) and the data cache (client DC).
- Sits between the two cache instances and the memory model/DRAM interface.
- Carries exactly one transaction at a time: arbitrate, address phase, then a write-data phase or a read-response phase.
- Read-response beats are routed back only to the client that issued the request.

Parameters:
- ADDR_W, 28, memory line-address width (`MEM_ADDR_BITS`).
- DATA_W, 128, memory data width (`MEM_DATA_BITS`).
- BEATS, 4, data beats per transaction (`MEM_DATA_CYCLES`); must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_req_valid/dc_req_valid  in  1  client request valid.
- ic_req_ready/dc_req_ready  out  1  client request accepted this cycle.
- ic_req_addr/dc_req_addr  in  ADDR_W  line address.
- ic_req_rw/dc_req_rw  in  1  1=write, 0=read.
- ic_req_data_valid/dc_req_data_valid  in  1  write beat valid.
- ic_req_data_ready/dc_req_data_ready  out  1  write beat accepted.
- ic_req_data_bits/dc_req_data_bits  in  DATA_W  write beat.
- ic_req_data_mask/dc_req_data_mask  in  DATA_W/8  byte mask.
- ic_resp_valid/dc_resp_valid  out  1  read beat for this client.
- ic_resp_data/dc_resp_data  out  DATA_W  read beat; both are driven from mem_resp_data.
- mem_req_valid  out  1.
- mem_req_ready  in  1.
- mem_req_addr  out  ADDR_W.
- mem_req_rw  out  1.
- mem_req_data_valid  out  1.
- mem_req_data_ready  in  1.
- mem_req_data_bits  out  DATA_W.
- mem_req_data_mask  out  DATA_W/8.
- mem_resp_valid  in  1.
- mem_resp_data  in  DATA_W.

Behaviour:
- States: IDLE, ADDR, WDATA, RRESP.
- Reset (asynchronous, reset=0):
  - state=IDLE, grant=IC, last=DC, beat counter=0.
  - All valid/ready outputs are 0.
  - mem_req_addr, mem_req_data_bits and mem_req_data_mask are 0 while not in ADDR/WDATA.
- IDLE:
  - If any client req_valid is high, register grant and go to ADDR.
  - No outputs are asserted in IDLE, so arbitration costs one bubble cycle: client valid at cycle t gives mem_req_valid at t+1.
- Arbitration:
  - Only one valid: that client wins.
  - Both valid: round-robin, the client not equal to `last` wins.
  - `last` updates to grant when the address handshake fires.
- ADDR:
  - mem_req_valid, addr and rw are driven combinationally from the granted client.
  - Granted req_ready = mem_req_ready; the other client's req_ready = 0.
  - On fire (valid&&ready): rw=1 → WDATA; rw=0 → RRESP. Counter is cleared in both cases.
  - Clients hold addr/rw stable while valid is high; a client must not drop valid before fire.
- WDATA:
  - mem_req_data_valid/bits/mask come from the granted client; granted data_ready = mem_req_data_ready.
  - Each fire increments the counter. The fire with counter==BEATS-1 goes to IDLE.
  - Writes produce no response.
- RRESP:
  - Granted resp_valid = mem_resp_valid; the other client's resp_valid = 0.
  - Each mem_resp_valid increments the counter. Counter==BEATS-1 goes to IDLE.
- mem_resp_valid outside RRESP is ignored and drives no client resp_valid.
- Data beats (data_valid) in IDLE/ADDR are not accepted: data_ready=0.
- Counter is $clog2(BEATS)+1 bits wide. With BEATS=1, the first beat ends the phase.
- Back-to-back transactions: the return to IDLE costs one cycle, so the next ADDR starts at the earliest 2 cycles after the last beat.
- Reset asserted mid-transaction: abort immediately to the reset state. An outstanding memory transaction is not cleaned up; memory is reset together with the arbiter.

Optional Feature:
- Macro MEM_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority; DC always wins when both are valid, and `last` is unused.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants (IDLE=0, ADDR=1, WDATA=2, RRESP=3).
  - client IDs (IC=0, DC=1).
- One natural sub-module: mem_arb_rr.
  - 2-input grant logic.
  - Inputs: two valids, last, prio-mode. Output: winner.

Test Plan:
- IC read alone: ic_req addr=0x0000123, rw=0; mem ready immediately; 4 resp beats 0xA0..0xA3 → mem_req_valid at cycle t+1, addr 0x0000123; ic_resp_valid high exactly 4 cycles with matching data; dc_resp_valid stays 0.
- DC write: addr=0x0ABCDEF, 4 beats 0x10..0x13, mask 0xFFFF; mem_req_data_ready toggles 1,0,1,1,1 → exactly 4 beats forwarded in order; return to IDLE; no resp_valid on either client.
- Simultaneous requests, both held valid for 3 transactions, reads, BEATS=4 → grants IC, DC, IC (round-robin). With MEM_ARB_DCACHE_PRIO_EN → DC, DC, DC while DC stays valid.
- Backpressure: mem_req_ready low for 5 cycles in ADDR → addr held stable; granted req_ready stays 0 until the fire cycle; the other client's req_ready stays 0.
- Stray response: mem_resp_valid pulsed in IDLE with data 0xDEAD → both resp_valid stay 0; state unchanged.
- Reset mid-RRESP after 2 beats → all outputs 0 asynchronously; next IC read completes normally with 4 beats.
